// File: rtl/fifo_peek_if.sv
// rtl/fifo_peek_if.sv - producer/consumer bundle for the peekable FIFO
interface fifo_peek_if #(
    parameter int B = 8,
    parameter int W = 4
);
    logic         clr;
    logic         wr;
    logic [B-1:0] w_data;
    logic         rd;
    logic [B-1:0] r_data;
    logic [W-1:0] peek_off;
    logic [B-1:0] peek_data;
    logic         peek_valid;
    logic [W:0]   count;
    logic         empty;
    logic         full;
    logic         almost_empty;
    logic         almost_full;
    logic         overflow;
    logic         underflow;
    logic         err_clr;

    modport master (
        output clr, wr, w_data, rd, peek_off, err_clr,
        input  r_data, peek_data, peek_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );

    modport slave (
        input  clr, wr, w_data, rd, peek_off, err_clr,
        output r_data, peek_data, peek_valid, count, empty, full,
               almost_empty, almost_full, overflow, underflow
    );
endinterface

// File: rtl/fifo_peek.sv
// rtl/fifo_peek.sv - FWFT synchronous FIFO with occupancy, thresholds, sticky errors and peek
module fifo_peek #(
    parameter int B  = 8,
    parameter int W  = 4,
    parameter int AE = 2,
    parameter int AF = 14
) (
    input  logic        clk,
    input  logic        reset,
    fifo_peek_if.slave  bus
);
    localparam int         DEPTH   = 1 << W;
    localparam logic [W:0] DEPTH_C = (W+1)'(DEPTH);
    localparam logic [W:0] AE_C    = (W+1)'(AE);
    localparam logic [W:0] AF_C    = (W+1)'(AF);

    logic [B-1:0] mem [DEPTH];
    logic [W-1:0] w_ptr, r_ptr, peek_idx;
    logic [W:0]   cnt, cnt_nxt;
    logic         empty_q, full_q, ae_q, af_q, ovf_q, unf_q;
    logic         wr_ok, rd_ok, ovf_set, unf_set;

    // When full, a simultaneous read frees the slot the write lands in.
    always_comb begin
        wr_ok   = 1'b0;
        rd_ok   = 1'b0;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        cnt_nxt = cnt;
        if (bus.clr) begin
            cnt_nxt = '0;
        end else begin
            wr_ok   = bus.wr & (~full_q | bus.rd);
            rd_ok   = bus.rd & ~empty_q;
            ovf_set = bus.wr & ~wr_ok;
            unf_set = bus.rd & ~rd_ok;
            cnt_nxt = cnt + (W+1)'(wr_ok) - (W+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            w_ptr   <= '0;
            r_ptr   <= '0;
            cnt     <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
            ae_q    <= 1'b1;
            af_q    <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (bus.clr) begin
                w_ptr <= '0;
                r_ptr <= '0;
            end else begin
                if (wr_ok) w_ptr <= w_ptr + W'(1);
                if (rd_ok) r_ptr <= r_ptr + W'(1);
            end
            cnt     <= cnt_nxt;
            empty_q <= (cnt_nxt == '0);
            full_q  <= (cnt_nxt == DEPTH_C);
            ae_q    <= (cnt_nxt <= AE_C);
            af_q    <= (cnt_nxt >= AF_C);
            // A rejection in the same cycle as err_clr keeps the bit set.
            ovf_q   <= ovf_set | (ovf_q & ~bus.err_clr);
            unf_q   <= unf_set | (unf_q & ~bus.err_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[w_ptr] <= bus.w_data;
    end

    assign peek_idx         = r_ptr + bus.peek_off;
    assign bus.r_data       = mem[r_ptr];
    assign bus.peek_data    = mem[peek_idx];
    assign bus.peek_valid   = ((W+1)'(bus.peek_off) < cnt);
    assign bus.count        = cnt;
    assign bus.empty        = empty_q;
    assign bus.full         = full_q;
    assign bus.almost_empty = ae_q;
    assign bus.almost_full  = af_q;
    assign bus.overflow     = ovf_q;
    assign bus.underflow    = unf_q;
endmodule

// File: tb/tb_fifo_peek.sv
// tb/tb_fifo_peek.sv - directed self-checking bench for fifo_peek
module tb_fifo_peek;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;

    fifo_peek_if #(.B(8), .W(4)) bus ();

    fifo_peek #(.B(8), .W(4), .AE(2), .AF(14)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock with the given controls, then sample 1ns after the edge.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r,
                       input logic c = 1'b0, input logic e = 1'b0);
        bus.wr = w; bus.w_data = d; bus.rd = r; bus.clr = c; bus.err_clr = e;
        @(posedge clk);
        #1;
        bus.wr = 1'b0; bus.rd = 1'b0; bus.clr = 1'b0; bus.err_clr = 1'b0;
    endtask

    initial begin
        bus.wr = 0; bus.rd = 0; bus.clr = 0; bus.err_clr = 0;
        bus.w_data = 0; bus.peek_off = 0;
        #12;
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ae", bus.almost_empty, 1);
        check("rst_af", bus.almost_full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_unf", bus.underflow, 0);
        @(negedge clk);
        reset = 1'b0;

        // 1: three writes, FWFT head and peek
        cyc(1, 8'h11, 0);
        check("t1_first_visible", bus.r_data, 8'h11);
        cyc(1, 8'h22, 0);
        cyc(1, 8'h33, 0);
        check("t1_count", bus.count, 3);
        check("t1_rdata", bus.r_data, 8'h11);
        check("t1_empty", bus.empty, 0);
        check("t1_ae", bus.almost_empty, 0);
        bus.peek_off = 2; #1;
        check("t1_peek2", bus.peek_data, 8'h33);
        check("t1_peek2_v", bus.peek_valid, 1);
        bus.peek_off = 3; #1;
        check("t1_peek3_v", bus.peek_valid, 0);

        // 2: fill to full, overflow, wr&rd while full
        cyc(0, 0, 0, 1);
        check("t2_clr_count", bus.count, 0);
        for (int i = 0; i < 16; i++) begin
            cyc(1, 8'(i), 0);
            if (i == 12) check("t2_af_at13", bus.almost_full, 0);
            if (i == 13) check("t2_af_at14", bus.almost_full, 1);
        end
        check("t2_full", bus.full, 1);
        check("t2_count16", bus.count, 16);
        cyc(1, 8'hEE, 0);
        check("t2_ovf_count", bus.count, 16);
        check("t2_ovf", bus.overflow, 1);
        cyc(0, 0, 0, 0, 1);
        check("t2_ovf_cleared", bus.overflow, 0);
        cyc(1, 8'hAA, 1);
        check("t2_wrrd_count", bus.count, 16);
        check("t2_wrrd_rdata", bus.r_data, 8'h01);
        check("t2_wrrd_ovf", bus.overflow, 0);
        check("t2_wrrd_full", bus.full, 1);
        bus.peek_off = 15; #1;
        check("t2_tail_aa", bus.peek_data, 8'hAA);

        // 3: wrap-around
        cyc(0, 0, 0, 1);
        for (int i = 0; i < 10; i++) cyc(1, 8'(i), 0);
        for (int i = 0; i < 10; i++) cyc(0, 0, 1);
        check("t3_empty_mid", bus.empty, 1);
        for (int i = 0; i < 12; i++) cyc(1, 8'(8'hA0 + i), 0);
        check("t3_count", bus.count, 12);
        check("t3_rdata", bus.r_data, 8'hA0);
        bus.peek_off = 11; #1;
        check("t3_peek11", bus.peek_data, 8'hAB);
        check("t3_peek11_v", bus.peek_valid, 1);
        for (int i = 0; i < 12; i++) begin
            check($sformatf("t3_pop%0d", i), bus.r_data, 32'(8'hA0 + i));
            cyc(0, 0, 1);
        end
        check("t3_final_count", bus.count, 0);
        check("t3_final_unf", bus.underflow, 0);

        // 4: wr&rd on empty, err_clr behaviour
        cyc(1, 8'h5C, 1);
        check("t4_count", bus.count, 1);
        check("t4_rdata", bus.r_data, 8'h5C);
        check("t4_unf", bus.underflow, 1);
        cyc(0, 0, 0, 0, 1);
        check("t4_unf_clr", bus.underflow, 0);
        cyc(0, 0, 1);
        check("t4_pop_count", bus.count, 0);
        check("t4_pop_unf", bus.underflow, 0);
        cyc(0, 0, 1, 0, 1);
        check("t4_unf_wins", bus.underflow, 1);

        // 5: clr with 7 entries plus wr&rd
        for (int i = 0; i < 7; i++) cyc(1, 8'(8'h60 + i), 0);
        check("t5_count7", bus.count, 7);
        cyc(1, 8'hFF, 1, 1);
        check("t5_count", bus.count, 0);
        check("t5_empty", bus.empty, 1);
        check("t5_ae", bus.almost_empty, 1);
        check("t5_ovf", bus.overflow, 0);
        check("t5_unf", bus.underflow, 1);
        cyc(1, 8'h77, 0);
        check("t5_rdata", bus.r_data, 8'h77);
        check("t5_count1", bus.count, 1);

        // 6: asynchronous reset between edges
        for (int i = 0; i < 4; i++) cyc(1, 8'(i), 0);
        check("t6_count5", bus.count, 5);
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("t6_count", bus.count, 0);
        check("t6_empty", bus.empty, 1);
        check("t6_ovf", bus.overflow, 0);
        check("t6_unf", bus.underflow, 0);
        @(negedge clk);
        reset = 1'b0;
        cyc(1, 8'h3C, 0);
        cyc(1, 8'h4D, 0);
        check("t6_resume_count", bus.count, 2);
        check("t6_resume_rdata", bus.r_data, 8'h3C);
        cyc(0, 0, 1);
        check("t6_resume_pop", bus.r_data, 8'h4D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
